// File: rtl/sram_arb_if.sv
// Two-port SRAM arbiter bus: client request/response signals plus the SRAM side.
interface sram_arb_if #(
  parameter int unsigned AW = 23,
  parameter int unsigned DW = 64
);
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [1:0]    req_we;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_wdata0;
  logic [DW-1:0] req_wdata1;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic          sram_we;
  logic [DW-1:0] sram_rdata;

  // Arbiter side
  modport slave (
    input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, sram_addr, sram_wdata, sram_we
  );

  // Client / SRAM environment side
  modport master (
    output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, sram_addr, sram_wdata, sram_we
  );
endinterface

// File: rtl/sram_arb.sv
// Two-port arbiter in front of a single-port synchronous SRAM, one request in flight.
// Optional macro SRAM_ARB_FIXED_PRIO_EN: port 0 always wins contention (no last-grant state);
// default build uses round-robin arbitration.
module sram_arb #(
  parameter int unsigned AW     = 23,
  parameter int unsigned DW     = 64,
  parameter int unsigned RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  sram_arb_if.slave  bus
);

  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          lat_we;
  logic          lat_port;
  logic [CW-1:0] wait_cnt;
  logic          win_c;
  logic [1:0]    grant_c;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic          last_gnt;
`endif

  // Pick the winning port from the current request vector
  always_comb begin
    win_c = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    win_c = ~bus.req_valid[0];
`else
    if (&bus.req_valid) win_c = ~last_gnt;
    else                win_c = ~bus.req_valid[0];
`endif
    grant_c = 2'b00;
    if (!rst && state == IDLE) grant_c = bus.req_valid & (2'b01 << win_c);
  end

  assign bus.req_ready = grant_c;

  // Request FSM with registered SRAM drive and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      lat_we         <= 1'b0;
      lat_port       <= 1'b0;
      wait_cnt       <= '0;
      bus.rsp_valid  <= 2'b00;
      bus.rsp_rdata  <= '0;
      bus.sram_addr  <= '0;
      bus.sram_wdata <= '0;
      bus.sram_we    <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last_gnt       <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|grant_c) begin
            bus.sram_addr  <= win_c ? bus.req_addr1  : bus.req_addr0;
            bus.sram_wdata <= win_c ? bus.req_wdata1 : bus.req_wdata0;
            bus.sram_we    <= bus.req_we[win_c];
            lat_we         <= bus.req_we[win_c];
            lat_port       <= win_c;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_gnt       <= win_c;
`endif
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.sram_we <= 1'b0;
          wait_cnt    <= '0;
          if (lat_we) begin
            bus.rsp_valid <= 2'b01 << lat_port;
            state         <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == CW'(RD_LAT - 1)) begin
            bus.rsp_rdata <= bus.sram_rdata;
            bus.rsp_valid <= 2'b01 << lat_port;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        RESP: begin
          bus.rsp_valid <= 2'b00;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sram_arb.md
SRAM_ARB -- requirements
Module: sram_arb

Interface
REQ-001 Parameter AW, default 23, SRAM address width.
REQ-002 Parameter DW, default 64, SRAM data width.
REQ-003 Parameter RD_LAT, default 1, cycles from read issue to valid sram_rdata; legal range 1..4.
REQ-004 The design SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  2  per-port request valid; bit n belongs to port n.
REQ-008 req_ready  output  2  per-port request accept.
REQ-009 req_we  input  2  per-port operation: 1 = write, 0 = read.
REQ-010 req_addr0 / req_addr1  input  AW  per-port address.
REQ-011 req_wdata0 / req_wdata1  input  DW  per-port write data.
REQ-012 rsp_valid  output  2  per-port one-cycle completion pulse.
REQ-013 rsp_rdata  output  DW  read data, valid with rsp_valid; shared by both ports.
REQ-014 sram_addr  output  AW  to SRAM address.
REQ-015 sram_wdata  output  DW  to SRAM data_in.
REQ-016 sram_we  output  1  to SRAM write_en.
REQ-017 sram_rdata  input  DW  from SRAM data_out.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-019 IDLE: req_ready SHALL be driven combinationally to the arbitration winner only, and only while that port's req_valid=1.
REQ-020 A handshake SHALL complete when req_valid[n]&&req_ready[n] is high at a clock edge; addr, wdata, we and the port id are latched and the FSM moves to ISSUE.
REQ-021 Outside IDLE, req_ready SHALL be 2'b00; at most one request is in flight.
REQ-022 ISSUE (1 cycle): sram_addr = latched addr, sram_wdata = latched wdata, sram_we = latched we.
REQ-023 A write SHALL go ISSUE -> RESP; a read SHALL go ISSUE -> WAIT.
REQ-024 A read SHALL stay in WAIT for RD_LAT cycles, then capture sram_rdata into rsp_rdata and go to RESP.
REQ-025 RESP (1 cycle): rsp_valid[port]=1, then return to IDLE; no new request is accepted in RESP.
REQ-026 Latency from handshake edge to rsp_valid SHALL be 2 cycles for a write and 2+RD_LAT cycles for a read.
REQ-027 For a write, rsp_rdata SHALL hold its previous value.
REQ-028 sram_we SHALL be 0 in every state except ISSUE of a write; sram_addr and sram_wdata hold their last value outside ISSUE.
REQ-029 Arbitration (default) SHALL be round-robin: when both ports are valid, the port not granted last wins; a lone valid port always wins.
REQ-030 The last-grant register SHALL update only on a completed handshake.
REQ-031 Address values SHALL pass unmodified; the full 0..2^AW-1 range is legal, with no wrap or check.
REQ-032 A change to req_valid or payload while the port is not granted SHALL have no effect.

Reset
REQ-033 While rst=1, the FSM SHALL go to IDLE, and req_ready, rsp_valid and sram_we SHALL be 0.
REQ-034 While rst=1, sram_addr, sram_wdata and rsp_rdata SHALL be 0, and last-grant SHALL be port 1, so port 0 wins the first contention.
REQ-035 Reset asserted mid-operation SHALL abort the request in flight with no rsp_valid and no further sram_we pulse.

Configuration
REQ-036 When SRAM_ARB_FIXED_PRIO_EN is defined, port 0 SHALL always win when both ports are valid, and the last-grant register is absent.
REQ-037 When SRAM_ARB_FIXED_PRIO_EN is undefined, arbitration SHALL be round-robin per REQ-029.

Verification
REQ-038 Port 0 write addr 0x000005, data 0x0123456789ABCDEF -> one sram_we pulse at that addr/data; rsp_valid[0] 2 cycles after handshake.
REQ-039 Port 1 read addr 0x000005 after REQ-038, RD_LAT=1 -> rsp_valid[1] 3 cycles after handshake; rsp_rdata = 0x0123456789ABCDEF.
REQ-040 Both ports continuously valid, 4 requests each, default build -> grants 0,1,0,1,0,1,0,1; with SRAM_ARB_FIXED_PRIO_EN defined -> the 4 port-0 grants come first.
REQ-041 Write 32 addresses 0..31 with data 0x1122334455667788+i, then read them back -> each rsp_rdata matches; addr 0x7FFFFF write/read round-trips.
REQ-042 rst asserted in WAIT of a read -> no rsp_valid; all outputs 0 on the next edge; the first request after reset is serviced normally.
REQ-043 RD_LAT=3 read -> rsp_valid exactly 5 cycles after handshake; req_ready stays 0 throughout.
